idct_mac8_seq: RTL and testbench



---
 rtl/idct_mac8_seq.sv | 174 +++++++++++++++++
 tb/tb_idct_mac8_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_mac8_seq.sv
// -----------------------------------------------------------------------------
// idct_mac8_seq
//
// Serial 8-point inverse DCT for one row. The block takes eight 2's-complement
// coefficients X[0..7] one at a time and stores them. It then rebuilds each
// spatial sample x[k] with one multiply-accumulate per cycle against a fixed
// 8-bit cosine table (scale 2^FRAC). Samples leave one at a time, in order
// k = 0..7, through a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   coefficient valid
//   in_ready   block can accept a coefficient (high only while loading)
//   in_coef    coefficient X[n], n = arrival order 0..7
//   out_valid  sample valid; held until accepted
//   out_ready  downstream accepts sample
//   out_pix    reconstructed sample x[k]
//   out_last   high together with out_valid for x[7]
// -----------------------------------------------------------------------------
module idct_mac8_seq #(
    parameter int COEF_W = 12,
    parameter int OUT_W  = 14,
    parameter int FRAC   = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_pix,
    output logic                     out_last
);

    localparam int CW     = 8;
    localparam int PROD_W = COEF_W + CW;
    // The sum of |C(k,n)| over a row is 337 < 2^9, so 3 growth bits above one
    // full-scale product are enough for eight products.
    localparam int ACC_W  = PROD_W + 3;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC - 1));

    typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;

    state_t                    state;
    logic [2:0]                n_cnt;
    logic [2:0]                k_cnt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [COEF_W-1:0]  coef_buf [8];

    logic signed [CW-1:0]      cos_w;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   mac_sum;

    // First quarter-wave of 64*cos(m*pi/16), m = 0..8.
    function automatic logic signed [CW-1:0] cos_t(input logic [3:0] i);
        case (i)
            4'd0:    return 8'sd64;
            4'd1:    return 8'sd63;
            4'd2:    return 8'sd59;
            4'd3:    return 8'sd53;
            4'd4:    return 8'sd45;
            4'd5:    return 8'sd36;
            4'd6:    return 8'sd24;
            4'd7:    return 8'sd12;
            default: return 8'sd0;
        endcase
    endfunction

    // C(k,n): the DC column uses 45 (64/sqrt2). Every other entry folds the
    // phase m = (2k+1)*n mod 32 back onto the quarter-wave table.
    function automatic logic signed [CW-1:0] cos_c(input logic [2:0] k,
                                                   input logic [2:0] n);
        logic [6:0]           phase;
        logic [4:0]           m;
        logic [4:0]           idx;
        logic signed [CW-1:0] c;
        phase = {3'b000, k, 1'b1} * {4'b0000, n};
        m     = phase[4:0];
        idx   = 5'd0;
        if (n == 3'd0) begin
            c = 8'sd45;
        end else if (m <= 5'd8) begin
            c = cos_t(m[3:0]);
        end else if (m <= 5'd16) begin
            idx = 5'd16 - m;
            c   = -cos_t(idx[3:0]);
        end else if (m <= 5'd24) begin
            idx = m - 5'd16;
            c   = -cos_t(idx[3:0]);
        end else begin
            idx = 5'd0 - m;             // 32 - m, modulo 32
            c   = cos_t(idx[3:0]);
        end
        return c;
    endfunction

    // Round half up, then drop the table scale. The output width always holds
    // the result (|x| <= 5392), so the truncation loses no information.
    function automatic logic signed [OUT_W-1:0] round_out(
        input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] r;
        r = (s + HALF) >>> FRAC;
        return r[OUT_W-1:0];
    endfunction

    assign in_ready = (state == S_LOAD);

    // MAC datapath: product of the current coefficient and cosine, added to acc
    always_comb begin
        cos_w   = cos_c(k_cnt, n_cnt);
        prod    = coef_buf[n_cnt] * cos_w;
        mac_sum = acc + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            n_cnt     <= 3'd0;
            k_cnt     <= 3'd0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < 8; i++) coef_buf[i] <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        coef_buf[n_cnt] <= in_coef;
                        n_cnt           <= n_cnt + 3'd1;   // wraps to 0 after X[7]
                        if (n_cnt == 3'd7) begin
                            k_cnt <= 3'd0;
                            acc   <= '0;
                            state <= S_MAC;
                        end
                    end
                end

                S_MAC: begin
                    acc   <= mac_sum;
                    n_cnt <= n_cnt + 3'd1;
                    // Output register stage: last product is folded in directly
                    if (n_cnt == 3'd7) begin
                        out_pix   <= round_out(mac_sum);
                        out_valid <= 1'b1;
                        out_last  <= (k_cnt == 3'd7);
                        state     <= S_OUT;
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        n_cnt     <= 3'd0;
                        acc       <= '0;
                        if (k_cnt == 3'd7) begin
                            k_cnt <= 3'd0;
                            state <= S_LOAD;
                        end else begin
                            k_cnt <= k_cnt + 3'd1;
                            state <= S_MAC;
                        end
                    end
                end

                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_idct_mac8_seq.sv
// -----------------------------------------------------------------------------
// tb_idct_mac8_seq
//
// Directed bench for idct_mac8_seq. Inputs are driven and outputs sampled on
// the falling clock edge. A transfer happens on the rising edge that follows.
// Expected samples are either hand-computed constants or come from a table
// model that uses the cosine matrix written out in full.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_idct_mac8_seq;

    localparam int COEF_W = 12;
    localparam int OUT_W  = 14;

    typedef int row_t [8];

    // C(k,n) with row = k (sample), column = n (frequency), scale 128
    localparam int CT [8][8] = '{
        '{45,  63,  59,  53,  45,  36,  24,  12},
        '{45,  53,  24, -12, -45, -63, -59, -36},
        '{45,  36, -24, -63, -45,  12,  59,  53},
        '{45,  12, -59, -36,  45,  53, -24, -63},
        '{45, -12, -59,  36,  45, -53, -24,  63},
        '{45, -36, -24,  63, -45, -12,  59, -53},
        '{45, -53,  24,  12, -45,  63, -59,  36},
        '{45, -63,  59, -53,  45, -36,  24, -12}
    };

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [COEF_W-1:0] in_coef = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [OUT_W-1:0]  out_pix;
    logic                     out_last;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int acc7_cyc = 0;
    int vld_cyc  = 0;
    int first_vld = 0;
    int last_cnt = 0;
    int samp_cnt = 0;

    idct_mac8_seq #(.COEF_W(COEF_W), .OUT_W(OUT_W), .FRAC(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_pix(input row_t x, input int k);
        int s;
        s = 0;
        for (int n = 0; n < 8; n++) s += x[n] * CT[k][n];
        return (s + 64) >>> 7;
    endfunction

    // Sends the first cnt coefficients of x. Called on a falling edge.
    task automatic send_row(input row_t x, input int cnt, input int max_gap);
        for (int i = 0; i < cnt; i++) begin
            int gap;
            int waited;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_coef  = COEF_W'(x[i]);
            waited   = 0;
            while (!in_ready && waited < 500) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (i == 7) acc7_cyc = cyc + 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Collects one sample. With stall > 0, out_ready stays low for that many
    // cycles once the sample is presented.
    task automatic get_sample(input int exp_pix, input logic exp_last,
                              input int stall, input string tag);
        int waited;
        waited    = 0;
        out_ready = (stall == 0);
        while (!out_valid && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        vld_cyc = cyc;
        if (stall > 0) begin
            for (int j = 0; j < stall; j++) begin
                chk({tag, "_stall_vld"}, out_valid, 1);
                chk({tag, "_stall_pix"}, out_pix, exp_pix);
                chk({tag, "_stall_rdy"}, in_ready, 0);
                @(negedge clk);
            end
            out_ready = 1'b1;
        end
        chk({tag, "_pix"}, out_pix, exp_pix);
        chk({tag, "_last"}, out_last, exp_last);
        if (out_last) last_cnt++;
        samp_cnt++;
        @(negedge clk);
    endtask

    task automatic collect_row(input row_t exp, input int stall_k, input string tag);
        for (int k = 0; k < 8; k++) begin
            get_sample(exp[k], (k == 7), (k == stall_k) ? 5 : 0,
                       $sformatf("%s_k%0d", tag, k));
            if (k == 0) first_vld = vld_cyc;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        row_t r;
        row_t r2;
        row_t exp;
        int   nv;
        int   waited;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pix", out_pix, 0);
        chk("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // DC row: every sample (128*45 + 64) >>> 7 = 45
        r   = '{128, 0, 0, 0, 0, 0, 0, 0};
        exp = '{45, 45, 45, 45, 45, 45, 45, 45};
        fork
            send_row(r, 8, 0);
            collect_row(exp, -1, "dc");
        join
        chk("dc_latency", first_vld - acc7_cyc, 8);

        // First harmonic
        r   = '{0, 128, 0, 0, 0, 0, 0, 0};
        exp = '{63, 53, 36, 12, -12, -36, -53, -63};
        fork
            send_row(r, 8, 0);
            collect_row(exp, -1, "h1");
        join

        // All -2048: x[k] = -16 * sum_n C(k,n)
        r   = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
        exp = '{-5392, 1488, -1168, 432, -656, 48, -368, -144};
        fork
            send_row(r, 8, 0);
            collect_row(exp, -1, "neg");
        join

        // Full-scale alternating row against the model, with backpressure on k=3
        r = '{2047, 2047, -2048, 2047, -2048, 2047, -2048, 2047};
        for (int k = 0; k < 8; k++) exp[k] = ref_pix(r, k);
        fork
            send_row(r, 8, 0);
            collect_row(exp, 3, "fs");
        join

        // Two back-to-back random rows with input gaps
        for (int i = 0; i < 8; i++) begin
            r[i]  = int'($urandom_range(4095, 0)) - 2048;
            r2[i] = int'($urandom_range(4095, 0)) - 2048;
        end
        last_cnt = 0;
        samp_cnt = 0;
        fork
            begin
                send_row(r, 8, 3);
                send_row(r2, 8, 3);
            end
            begin
                for (int k = 0; k < 8; k++)
                    get_sample(ref_pix(r, k), (k == 7), 0, $sformatf("b2b_a_k%0d", k));
                for (int k = 0; k < 8; k++)
                    get_sample(ref_pix(r2, k), (k == 7), 0, $sformatf("b2b_b_k%0d", k));
            end
        join
        chk("b2b_count", samp_cnt, 16);
        chk("b2b_lasts", last_cnt, 2);

        // Reset after four coefficients, then a fresh row
        r = '{100, 200, 300, 400, 500, 600, 700, 800};
        send_row(r, 4, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_out_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        r   = '{0, 0, 128, 0, 0, 0, 0, 0};
        exp = '{59, 24, -24, -59, -59, -24, 24, 59};
        fork
            send_row(r, 8, 0);
            collect_row(exp, -1, "fresh");
        join
        nv = 0;
        repeat (20) begin
            if (out_valid) nv++;
            @(negedge clk);
        end
        chk("fresh_extra_vld", nv, 0);

        // Reset while a sample is waiting in OUT
        out_ready = 1'b0;
        r = '{128, 0, 0, 0, 0, 0, 0, 0};
        send_row(r, 8, 0);
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_out_pre_vld", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_async_vld", out_valid, 0);
        chk("rst_out_async_rdy", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("rst_out_no_escape", nv, 0);

        // Recovery after that reset
        r   = '{0, 128, 0, 0, 0, 0, 0, 0};
        exp = '{63, 53, 36, 12, -12, -36, -53, -63};
        fork
            send_row(r, 8, 0);
            collect_row(exp, -1, "recov");
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
